// File: rtl/video_offset_crop_if.sv
// Pixel-stream bundle for the offset crop: sensor-side inputs, live offsets and the re-timed window stream.
interface video_offset_crop_if #(
    parameter int DATA_W = 10
);
    logic              iFVAL;
    logic              iLVAL;
    logic [DATA_W-1:0] iDATA;
    logic [15:0]       iX_OFF;
    logic [15:0]       iY_OFF;
    logic              oFVAL;
    logic              oLVAL;
    logic [DATA_W-1:0] oDATA;
    logic [15:0]       oX_POS;
    logic [15:0]       oY_POS;
    logic              oFRAME_DONE;
    logic              oCLAMP;

    modport master (
        output iFVAL, iLVAL, iDATA, iX_OFF, iY_OFF,
        input  oFVAL, oLVAL, oDATA, oX_POS, oY_POS, oFRAME_DONE, oCLAMP
    );

    modport slave (
        input  iFVAL, iLVAL, iDATA, iX_OFF, iY_OFF,
        output oFVAL, oLVAL, oDATA, oX_POS, oY_POS, oFRAME_DONE, oCLAMP
    );
endinterface

// File: rtl/video_offset_crop.sv
// Crops an OUT_W x OUT_H window at offsets latched on each FVAL rise; every output registered, 1 cycle latency.
// No backpressure: the stream runs at the sensor pixel clock and the window is simply gated out of it.
module video_offset_crop #(
    parameter int DATA_W = 10,
    parameter int IN_W   = 752,
    parameter int IN_H   = 480,
    parameter int OUT_W  = 720,
    parameter int OUT_H  = 480
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    video_offset_crop_if.slave bus
);
    typedef enum logic [1:0] {S_SYNC, S_WAIT, S_ACTIVE} state_t;

    localparam logic [15:0] X_MAX   = 16'(IN_W - OUT_W);
    localparam logic [15:0] Y_MAX   = 16'(IN_H - OUT_H);
    localparam logic [16:0] OUT_W17 = 17'(OUT_W);
    localparam logic [16:0] OUT_H17 = 17'(OUT_H);

    state_t      state;
    logic        fval_q;
    logic        lval_q;
    logic [15:0] col;
    logic [15:0] row;
    logic [15:0] xo;
    logic [15:0] yo;

    logic        fval_rise;
    logic        latch;
    logic        run;
    logic        x_clamp;
    logic        y_clamp;
    logic        in_win;
    logic [15:0] x_lim;
    logic [15:0] y_lim;
    logic [15:0] col_c;
    logic [15:0] row_c;
    logic [15:0] xo_c;
    logic [15:0] yo_c;

    // On the latch cycle the pixel already uses col 0 / row 0 and the freshly clamped offsets.
    always_comb begin
        fval_rise = bus.iFVAL && !fval_q;
        latch     = (state == S_WAIT) && fval_rise;
        run       = latch || ((state == S_ACTIVE) && bus.iFVAL);
        x_clamp   = bus.iX_OFF > X_MAX;
        y_clamp   = bus.iY_OFF > Y_MAX;
        x_lim     = x_clamp ? X_MAX : bus.iX_OFF;
        y_lim     = y_clamp ? Y_MAX : bus.iY_OFF;
        col_c     = latch ? 16'd0 : col;
        row_c     = latch ? 16'd0 : row;
        xo_c      = latch ? x_lim : xo;
        yo_c      = latch ? y_lim : yo;
        in_win    = run && bus.iLVAL
                 && ({1'b0, col_c} >= {1'b0, xo_c})
                 && ({1'b0, col_c} <  ({1'b0, xo_c} + OUT_W17))
                 && ({1'b0, row_c} >= {1'b0, yo_c})
                 && ({1'b0, row_c} <  ({1'b0, yo_c} + OUT_H17));
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state           <= S_SYNC;
            fval_q          <= 1'b0;
            lval_q          <= 1'b0;
            col             <= '0;
            row             <= '0;
            xo              <= '0;
            yo              <= '0;
            bus.oFVAL       <= 1'b0;
            bus.oLVAL       <= 1'b0;
            bus.oDATA       <= '0;
            bus.oX_POS      <= '0;
            bus.oY_POS      <= '0;
            bus.oFRAME_DONE <= 1'b0;
            bus.oCLAMP      <= 1'b0;
        end else begin
            fval_q          <= bus.iFVAL;
            lval_q          <= bus.iLVAL;
            bus.oFVAL       <= run;
            bus.oLVAL       <= in_win;
            bus.oDATA       <= in_win ? bus.iDATA : '0;
            bus.oFRAME_DONE <= 1'b0;
            if (in_win) begin
                bus.oX_POS <= col_c - xo_c;
                bus.oY_POS <= row_c - yo_c;
            end
            case (state)
                S_SYNC: begin
                    if (!bus.iFVAL) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fval_rise) begin
                        state      <= S_ACTIVE;
                        xo         <= x_lim;
                        yo         <= y_lim;
                        bus.oCLAMP <= x_clamp || y_clamp;
                        row        <= '0;
                        col        <= bus.iLVAL ? 16'd1 : 16'd0;
                    end
                end
                S_ACTIVE: begin
                    if (!bus.iFVAL) begin
                        state           <= S_WAIT;
                        bus.oFRAME_DONE <= 1'b1;
                    end else if (bus.iLVAL) begin
                        if (col != 16'hFFFF) col <= col + 16'd1;
                    end else if (lval_q) begin
                        col <= '0;
                        if (row != 16'hFFFF) row <= row + 16'd1;
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end
endmodule

// File: doc/video_offset_crop.md
Name: video_offset_crop

Overview:
Consumer side of the key-driven X/Y offset counters. Takes the MT9V034 parallel pixel stream (FVAL/LVAL/DATA) and the live offset values iX_OFF/iY_OFF. Crops a fixed OUT_W x OUT_H window positioned at those offsets and outputs it as a re-timed pixel stream for the display path. Offsets are sampled once per frame, so key presses never tear a frame.

Parameters:
DATA_W, 10, pixel data width
IN_W, 752, active pixels per input line
IN_H, 480, active lines per input frame
OUT_W, 720, output window width (OUT_W <= IN_W)
OUT_H, 480, output window height (OUT_H <= IN_H)

Ports:
iCLK  in  1  pixel clock
iRST_N  in  1  reset; asynchronous, active-low
iFVAL  in  1  input frame valid
iLVAL  in  1  input line valid (only meaningful while iFVAL=1)
iDATA  in  DATA_W  input pixel
iX_OFF  in  16  requested horizontal window offset, pixels
iY_OFF  in  16  requested vertical window offset, lines
oFVAL  out  1  output frame valid
oLVAL  out  1  output line valid (window pixels only)
oDATA  out  DATA_W  output pixel, 0 when oLVAL=0
oX_POS  out  16  column of the current output pixel within the window
oY_POS  out  16  row of the current output pixel within the window
oFRAME_DONE  out  1  one-cycle pulse at the end of each fully processed frame
oCLAMP  out  1  offset for the current frame was clamped

Behaviour:
- Reset: all outputs 0. State goes to S_SYNC, and internal counters and shadow offsets are cleared.
- Latency: every output is registered exactly 1 cycle after the input sample it derives from.
- States:
  - S_SYNC: wait for iFVAL=0, then go to S_WAIT. This discards any partial frame after reset.
  - S_WAIT: on an iFVAL rising edge (iFVAL=1 while the previous iFVAL=0), latch offsets and go to S_ACTIVE.
  - S_ACTIVE: on iFVAL=0, pulse oFRAME_DONE for 1 cycle and return to S_WAIT.
- Offset latch happens on the FVAL rising edge only. Clamping rules:
  - xo = min(iX_OFF, IN_W-OUT_W); yo = min(iY_OFF, IN_H-OUT_H).
  - oCLAMP = 1 if either value was clamped; it holds for the whole frame and is recomputed at the next latch.
  - Changes on iX_OFF/iY_OFF mid-frame are ignored.
- Counters, active in S_ACTIVE only:
  - col increments on each cycle with iLVAL=1. It is cleared on the cycle after an iLVAL falling edge and saturates at 16'hFFFF.
  - row increments on each iLVAL falling edge and is cleared at the FVAL rising edge. It saturates at 16'hFFFF.
- Window condition: (col >= xo) && (col < xo+OUT_W) && (row >= yo) && (row < yo+OUT_H) && iLVAL. All comparisons use 17-bit arithmetic, so there is no wrap.
- Output stream:
  - oLVAL = window condition, registered.
  - oDATA = iDATA when in window, else 0.
  - oX_POS = col-xo and oY_POS = row-yo when in window; both hold their last value otherwise.
  - oFVAL is iFVAL registered, but only in S_ACTIVE and on the S_ACTIVE exit cycle; it is 0 in S_SYNC and S_WAIT.
- Short or long input lines: pixels beyond IN_W are never in the window. A short line gives a short output line with no padding.
- iFVAL falls mid-line: that line ends, oLVAL drops the next cycle, and the frame is counted as done.
- iLVAL=1 while iFVAL=0: ignored.
- Reset mid-frame: outputs drop to 0 asynchronously. No output until a complete new frame starts (S_SYNC requirement).
- Simultaneous FVAL rise and LVAL=1 on the same cycle: that pixel counts as col 0, row 0, using the newly latched offsets.

Test Plan:
Bench parameters: IN_W=16, IN_H=8, OUT_W=8, OUT_H=4, iDATA = row*16+col.
1. iX_OFF=4, iY_OFF=2, one full frame -> 4 output lines of 8 pixels each. First output pixel is data 36 at oX_POS=0, oY_POS=0, 1 cycle after the input. Last pixel is data 91. oFRAME_DONE pulses once after iFVAL falls.
2. iX_OFF=20, iY_OFF=9 -> clamped to xo=8, yo=4. oCLAMP=1 for the frame, and the first output pixel is data 72.
3. iX_OFF changed 2->6 mid-frame -> the current frame keeps xo=2 on every line; the next frame uses xo=6.
4. Release reset while iFVAL=1 mid-frame -> no oFVAL/oLVAL for the rest of that frame; the next full frame is output normally.
5. iFVAL dropped after 5 pixels of input row 3 (window yo=2, xo=0) -> 5 output pixels on output row 1, oLVAL low the next cycle, and one oFRAME_DONE pulse.
6. Assert reset during an active window line -> all outputs read 0 in the same cycle, before any clock edge.
